apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 Parameter N, default 8: data width; matches the exe unit operand and result width.
REQ-002 Parameter ADDR_W, default 4: APB address width.
REQ-003 Parameter TIMEOUT, default 16: maximum number of ACCESS cycles with pready low before the transfer is aborted; range 2..255.
REQ-004 clk  in  1  single clock for the block; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  in  1  a command is offered.
REQ-007 cmd_ready  out  1  the block can accept a command.
REQ-008 cmd_write  in  1  1 selects write, 0 selects read.
REQ-009 cmd_addr  in  ADDR_W  target register address.
REQ-010 cmd_wdata  in  N  write data; ignored on reads.
REQ-011 rsp_valid  out  1  one-cycle pulse: response fields are valid.
REQ-012 rsp_rdata  out  N  read data; 0 for writes, errors and timeouts.
REQ-013 rsp_error  out  1  pslverr was seen, or a timeout occurred.
REQ-014 rsp_timeout  out  1  the transfer was aborted by timeout.
REQ-015 psel, penable, pwrite  out  1 each  APB requester controls.
REQ-016 paddr  out  ADDR_W; pwdata  out  N: APB address and write data.
REQ-017 prdata  in  N; pready  in  1; pslverr  in  1: APB responder returns.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE, and 0 in every other state.
REQ-020 IDLE with cmd_valid=1: the block SHALL latch cmd_write, cmd_addr and cmd_wdata, then go to SETUP; with cmd_valid=0 it SHALL stay in IDLE.
REQ-021 SETUP: psel=1 and penable=0, with the latched paddr, pwrite and pwdata driven; the next state SHALL be ACCESS unconditionally.
REQ-022 ACCESS: psel=1 and penable=1; paddr, pwrite and pwdata SHALL hold the values driven in SETUP.
REQ-023 ACCESS with pready=1: the block SHALL capture prdata (reads only) and pslverr, then go to RESP.
REQ-024 ACCESS with pready=0: the wait counter SHALL increment.
  - If the counter reaches TIMEOUT: go to RESP with timeout flagged.
  - psel and penable SHALL drop to 0 in the cycle that follows.
REQ-025 The wait counter SHALL clear on entry to SETUP and SHALL be ceil(log2(TIMEOUT+1)) bits wide.
REQ-026 RESP: rsp_valid=1 for exactly one cycle, psel=penable=0, then the next state SHALL be IDLE.
REQ-027 rsp_rdata SHALL be prdata for a completed read with pslverr=0, and 0 in every other case.
REQ-028 rsp_error SHALL equal pslverr OR timeout, and rsp_timeout SHALL equal timeout.
  - Response fields SHALL hold their values until the next RESP.
REQ-029 Minimum latency: command accepted at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3 when pready=1 at T+2, cmd_ready at T+4.
REQ-030 A command offered while cmd_ready=0 SHALL be neither accepted nor lost; the source holds it until cmd_ready=1.
REQ-031 A pready or pslverr pulse outside ACCESS SHALL be ignored.
REQ-032 pslverr SHALL be sampled only in the ACCESS cycle in which pready=1.
REQ-033 All outputs SHALL be registered, with no combinational path from inputs to outputs.
  - Exception: cmd_ready may be decoded directly from the state register.
REQ-034 Back-to-back commands SHALL each take a full IDLE-SETUP-ACCESS-RESP sequence; no transfer pipelining.

Reset
REQ-035 Asserting rst SHALL immediately force the following, regardless of clk:
  - state to IDLE and the wait counter to 0;
  - psel, penable, pwrite, rsp_valid, rsp_error and rsp_timeout to 0;
  - paddr, pwdata and rsp_rdata to 0;
  - cmd_ready to 1 while rst is asserted.
REQ-036 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid.
  - The first command after rst deasserts SHALL be accepted on the first rising edge.

Verification
REQ-037 Write with zero wait:
  - Stimulus: write, addr=4'h2, wdata=8'h1A; responder pready=1.
  - Required: SETUP then ACCESS with pwdata=8'h1A; rsp_valid at T+3; rsp_error=0; rsp_rdata=0.
REQ-038 Read with two wait states:
  - Stimulus: read, addr=4'h3; responder drives prdata=8'h68, with pready low for 2 ACCESS cycles.
  - Required: ACCESS lasts 3 cycles; rsp_rdata=8'h68; rsp_valid at T+5.
REQ-039 Slave error:
  - Stimulus: read; pslverr=1 with pready=1 and prdata=8'hFF.
  - Required: rsp_error=1, rsp_timeout=0, rsp_rdata=0.
REQ-040 Timeout:
  - Stimulus: TIMEOUT=16; pready tied low.
  - Required: exactly 16 ACCESS cycles, then psel=0, rsp_valid=1, rsp_error=1, rsp_timeout=1.
REQ-041 Reset mid-transfer:
  - Stimulus: assert rst in the ACCESS cycle between clock edges.
  - Required: psel=penable=0 at once; no rsp_valid; a command after release completes normally.
REQ-042 Back-to-back commands:
  - Stimulus: cmd_valid held high with two commands queued.
  - Required: second accepted at T+4; there is a psel=0 gap between the transfers.

Source files
------------

// File: rtl/apb_requester_if.sv
// Bundle for apb_requester: command in, response out, and APB requester pins.
// The master modport is the requester's view. The slave modport is the
// environment's view: command source, response sink and APB responder.
interface apb_requester_if #(
   parameter int unsigned N      = 8,
   parameter int unsigned ADDR_W = 4
) ();

   // command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [N-1:0]      cmd_wdata;

   // response channel
   logic              rsp_valid;
   logic [N-1:0]      rsp_rdata;
   logic              rsp_error;
   logic              rsp_timeout;

   // APB
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [N-1:0]      pwdata;
   logic [N-1:0]      prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  prdata, pready, pslverr,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output prdata, pready, pslverr,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );

endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester.
// It takes one command at a time and runs it as one APB transfer
// (IDLE -> SETUP -> ACCESS -> RESP). It returns a one-cycle response pulse.
// A transfer whose responder stalls for TIMEOUT ACCESS cycles is aborted and
// reported as a timeout. Every output comes from a flop. The only exception
// is cmd_ready, which is decoded from the state register.
module apb_requester #(
   parameter int unsigned N       = 8,
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   apb_requester_if.master       bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StAccess = 2'd2,
      StResp   = 2'd3
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  wait_cnt_q;

   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [N-1:0]      pwdata_q;

   logic              rsp_valid_q;
   logic [N-1:0]      rsp_rdata_q;
   logic              rsp_error_q;
   logic              rsp_timeout_q;

   // The last stalled cycle before the abort. One more low pready reaches TIMEOUT.
   logic              wait_last;
   assign wait_last = (wait_cnt_q == CNT_W'(TIMEOUT - 1));

   // Transfer FSM. It also updates every registered APB and response output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         wait_cnt_q    <= '0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.cmd_valid) begin
                  // The command is captured straight into the APB drive registers.
                  pwrite_q   <= bus.cmd_write;
                  paddr_q    <= bus.cmd_addr;
                  pwdata_q   <= bus.cmd_wdata;
                  psel_q     <= 1'b1;
                  penable_q  <= 1'b0;
                  wait_cnt_q <= '0;
                  state_q    <= StSetup;
               end
            end

            StSetup: begin
               penable_q <= 1'b1;
               state_q   <= StAccess;
            end

            StAccess: begin
               if (bus.pready) begin
                  // A completion wins over a timeout that would land in the same cycle.
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_error_q   <= bus.pslverr;
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                  state_q       <= StResp;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
                  if (wait_last) begin
                     psel_q        <= 1'b0;
                     penable_q     <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     rsp_error_q   <= 1'b1;
                     rsp_timeout_q <= 1'b1;
                     rsp_rdata_q   <= '0;
                     state_q       <= StResp;
                  end
               end
            end

            StResp: begin
               // Response fields stay stable until the next response. Only the strobe drops.
               rsp_valid_q <= 1'b0;
               state_q     <= StIdle;
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.cmd_ready   = (state_q == StIdle);

   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_error   = rsp_error_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester.
// A table of transfers is replayed against the DUT. Each transfer has its own
// responder wait count and error/data choice. The expected response, latency
// and ACCESS length come from the transfer's parameters alone.
module tb_apb_requester;

   localparam int unsigned N       = 8;
   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int          NTXN    = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   apb_requester_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

   apb_requester #(.N(N), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit                wr;
      logic [ADDR_W-1:0] addr;
      logic [N-1:0]      wdata;
      int unsigned       w;       // ACCESS cycles with pready low before the responder answers
      bit                slverr;
      logic [N-1:0]      rdata;
      bit                b2b;     // keep cmd_valid high with the next command queued
   } txn_t;

   txn_t txns [NTXN];

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Responder noise outside the ACCESS cycles it should answer in.
   task automatic junk();
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = N'($urandom);
   endtask

   task automatic drive_cmd(input int i);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = txns[i].wr;
      bus.cmd_addr  = txns[i].addr;
      bus.cmd_wdata = txns[i].wdata;
   endtask

   task automatic drop_cmd();
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = ADDR_W'($urandom);
      bus.cmd_wdata = N'($urandom);
   endtask

   // Called #1 after a rising edge, with the DUT expected to be idle.
   task automatic run_txn(input int i);
      txn_t         t;
      int           cyc;
      int           acc;
      int           exp_acc;
      bit           exp_to;
      bit           exp_err;
      logic [N-1:0] exp_rd;
      t       = txns[i];
      exp_to  = (t.w >= TIMEOUT);
      exp_acc = exp_to ? int'(TIMEOUT) : int'(t.w) + 1;
      exp_err = exp_to || t.slverr;
      exp_rd  = (!exp_to && !t.wr && !t.slverr) ? t.rdata : '0;

      check_eq("cmd_ready_idle", bus.cmd_ready, 1'b1);
      drive_cmd(i);
      junk();
      @(posedge clk); #1;
      cyc = 1;
      acc = 0;
      if (t.b2b && i + 1 < NTXN) drive_cmd(i + 1);
      else drop_cmd();
      check_eq("setup_penable", bus.penable, 1'b0);

      while (!bus.rsp_valid && cyc <= int'(TIMEOUT) + 8) begin
         check_eq("psel_held", bus.psel, 1'b1);
         check_eq("paddr", bus.paddr, t.addr);
         check_eq("pwrite", bus.pwrite, t.wr);
         if (t.wr) check_eq("pwdata", bus.pwdata, t.wdata);
         check_eq("cmd_ready_busy", bus.cmd_ready, 1'b0);
         if (bus.psel && bus.penable) begin
            if (acc == int'(t.w)) begin
               bus.pready  = 1'b1;
               bus.pslverr = t.slverr;
               bus.prdata  = t.rdata;
            end else begin
               bus.pready  = 1'b0;
               bus.pslverr = 1'($urandom);
               bus.prdata  = N'($urandom);
            end
            acc++;
         end else begin
            junk();
         end
         @(posedge clk); #1;
         cyc++;
      end

      check_eq("rsp_valid_seen", bus.rsp_valid, 1'b1);
      check_eq("rsp_latency", cyc, exp_acc + 2);
      check_eq("access_cycles", acc, exp_acc);
      check_eq("resp_psel", bus.psel, 1'b0);
      check_eq("resp_penable", bus.penable, 1'b0);
      check_eq("rsp_error", bus.rsp_error, exp_err);
      check_eq("rsp_timeout", bus.rsp_timeout, exp_to);
      check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
      junk();
      @(posedge clk); #1;
      check_eq("rsp_pulse_one", bus.rsp_valid, 1'b0);
      check_eq("cmd_ready_back", bus.cmd_ready, 1'b1);
      check_eq("gap_psel", bus.psel, 1'b0);
      check_eq("rsp_error_hold", bus.rsp_error, exp_err);
      check_eq("rsp_rdata_hold", bus.rsp_rdata, exp_rd);
   endtask

   task automatic reset_mid_transfer();
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 4'h9;
      bus.cmd_wdata = 8'h55;
      @(posedge clk); #1;
      drop_cmd();
      bus.pready = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_pre_access", bus.penable, 1'b1);
      bus.pready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_eq("rst_psel", bus.psel, 1'b0);
      check_eq("rst_penable", bus.penable, 1'b0);
      check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("rst_paddr", bus.paddr, 4'h0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
      junk();
      @(posedge clk); #1;
      check_eq("rst_no_rsp", bus.rsp_valid, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      // Directed entries first, then random ones.
      txns[0] = '{wr: 1'b1, addr: 4'h2, wdata: 8'h1A, w: 0, slverr: 1'b0, rdata: 8'h00, b2b: 1'b0};
      txns[1] = '{wr: 1'b0, addr: 4'h3, wdata: 8'h00, w: 2, slverr: 1'b0, rdata: 8'h68, b2b: 1'b0};
      txns[2] = '{wr: 1'b0, addr: 4'h7, wdata: 8'h00, w: 0, slverr: 1'b1, rdata: 8'hFF, b2b: 1'b0};
      txns[3] = '{wr: 1'b0, addr: 4'h5, wdata: 8'h00, w: TIMEOUT + 5, slverr: 1'b0, rdata: 8'h99,
                  b2b: 1'b0};
      txns[4] = '{wr: 1'b1, addr: 4'hA, wdata: 8'hC3, w: 0, slverr: 1'b0, rdata: 8'h00, b2b: 1'b1};
      txns[5] = '{wr: 1'b0, addr: 4'hB, wdata: 8'h00, w: 1, slverr: 1'b0, rdata: 8'h3C, b2b: 1'b0};
      for (int i = 6; i < NTXN; i++) begin
         int unsigned r;
         r = $urandom_range(0, 9);
         txns[i].wr     = 1'($urandom);
         txns[i].addr   = ADDR_W'($urandom);
         txns[i].wdata  = N'($urandom);
         txns[i].slverr = ($urandom_range(0, 3) == 0);
         txns[i].rdata  = N'($urandom);
         txns[i].b2b    = (i < NTXN - 1) ? 1'($urandom) : 1'b0;
         if (r == 7)      txns[i].w = TIMEOUT - 1;
         else if (r == 8) txns[i].w = TIMEOUT;
         else if (r == 9) txns[i].w = TIMEOUT + 3;
         else             txns[i].w = $urandom_range(0, 3);
      end

      drop_cmd();
      junk();
      #1 rst = 1'b1;
      #1;
      check_eq("reset_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("reset_psel", bus.psel, 1'b0);
      check_eq("reset_penable", bus.penable, 1'b0);
      check_eq("reset_pwrite", bus.pwrite, 1'b0);
      check_eq("reset_paddr", bus.paddr, 4'h0);
      check_eq("reset_pwdata", bus.pwdata, 8'h00);
      check_eq("reset_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("reset_rsp_rdata", bus.rsp_rdata, 8'h00);
      check_eq("reset_rsp_error", bus.rsp_error, 1'b0);
      check_eq("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < NTXN; i++) begin
         run_txn(i);
         if (i == 5) reset_mid_transfer();
         else if (!txns[i].b2b) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               drop_cmd();
               junk();
               @(posedge clk); #1;
               check_eq("idle_psel", bus.psel, 1'b0);
               check_eq("idle_rsp_valid", bus.rsp_valid, 1'b0);
               check_eq("idle_cmd_ready", bus.cmd_ready, 1'b1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
